// File: rtl/day6.sv
// day6: 4-bit serial-in, parallel-out shift register.
// Newest serial bit lands in sr_o[0]; the oldest bit in sr_o[3] is dropped on each shift.
module day6 (
    input  logic       clk,
    input  logic       reset,
    input  logic       x_i,
    output logic [3:0] sr_o
);

    logic [3:0] sr_q;
    logic [3:0] sr_d;

    always_comb begin
        sr_d = {sr_q[2:0], x_i};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= 4'b0000;
        end else begin
            sr_q <= sr_d;
        end
    end

    // The output comes straight from the register, so it cannot glitch between edges.
    assign sr_o = sr_q;

endmodule

// File: tb/tb_day6.sv
// Self-checking bench for day6: directed shift patterns, reset behaviour and a random stream
// compared against a history of the sampled serial bits.
module tb_day6;

    logic       clk;
    logic       reset;
    logic       x_i;
    logic [3:0] sr_o;

    int errors = 0;
    int checks = 0;

    day6 dut (
        .clk   (clk),
        .reset (reset),
        .x_i   (x_i),
        .sr_o  (sr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic tick(input logic x, input logic r);
        @(negedge clk);
        x_i   = x;
        reset = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1);
        checks++;
        if (sr_o !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset: sr_o=%b expected=%b", sr_o, 4'b0000);
        end
    endtask

    task automatic test_pattern();
        logic [3:0] expv [4];
        logic       xs   [4];
        expv = '{4'b0001, 4'b0010, 4'b0101, 4'b1010};
        xs   = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            tick(xs[i], 1'b0);
            checks++;
            if (sr_o !== expv[i]) begin
                errors++;
                $display("[TB] FAIL pattern[%0d]: sr_o=%b expected=%b", i, sr_o, expv[i]);
            end
        end
    endtask

    task automatic test_flush();
        logic [3:0] expv [3];
        expv = '{4'b0100, 4'b1000, 4'b0000};
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (sr_o !== expv[i]) begin
                errors++;
                $display("[TB] FAIL flush[%0d]: sr_o=%b expected=%b", i, sr_o, expv[i]);
            end
        end
    endtask

    task automatic test_fill_drain();
        logic [3:0] fillv  [4];
        logic [3:0] drainv [4];
        fillv  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        drainv = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (sr_o !== fillv[i]) begin
                errors++;
                $display("[TB] FAIL fill[%0d]: sr_o=%b expected=%b", i, sr_o, fillv[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (sr_o !== drainv[i]) begin
                errors++;
                $display("[TB] FAIL drain[%0d]: sr_o=%b expected=%b", i, sr_o, drainv[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        checks++;
        if (sr_o !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL mid_reset_load: sr_o=%b expected=%b", sr_o, 4'b1011);
        end
        tick(1'b1, 1'b1);
        checks++;
        if (sr_o !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL mid_reset_clear: sr_o=%b expected=%b", sr_o, 4'b0000);
        end
        tick(1'b1, 1'b0);
        checks++;
        if (sr_o !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL mid_reset_resume: sr_o=%b expected=%b", sr_o, 4'b0001);
        end
    endtask

    // A reset pulse that rises and falls between two rising edges must not clear anything.
    task automatic test_reset_glitch();
        tick(1'b0, 1'b0);
        @(negedge clk);
        x_i   = 1'b1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (sr_o !== 4'b0101) begin
            errors++;
            $display("[TB] FAIL reset_glitch: sr_o=%b expected=%b", sr_o, 4'b0101);
        end
    endtask

    task automatic test_random();
        logic       bits[$];
        logic [3:0] expv;
        logic       b;
        int         n;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 200; i++) begin
            b = 1'($urandom_range(0, 1));
            bits.push_back(b);
            tick(b, 1'b0);
            n = bits.size();
            for (int k = 0; k < 4; k++) begin
                expv[k] = (n > k) ? bits[n-1-k] : 1'b0;
            end
            checks++;
            if (sr_o !== expv) begin
                errors++;
                $display("[TB] FAIL random[%0d]: sr_o=%b expected=%b", i, sr_o, expv);
            end
        end
    endtask

    initial begin
        x_i   = 1'b0;
        reset = 1'b0;
        test_reset();
        test_pattern();
        test_flush();
        test_fill_drain();
        test_mid_reset();
        test_reset_glitch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
